scratch_mem_resp: RTL

SCRATCH_MEM_RESP -- requirements
Module: scratch_mem_resp

---
 rtl/scratch_mem_resp.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/scratch_mem_resp.sv
// Word-organised scratch memory answering one request at a time after a fixed LATENCY.
// Define SCRATCH_MEM_MISALIGN_EN to add resp_err and suppress misaligned accesses.
module scratch_mem_resp #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_fcn,
    input  logic [2:0]  req_typ,
    output logic        resp_valid,
    output logic [31:0] resp_data
`ifdef SCRATCH_MEM_MISALIGN_EN
    ,
    output logic        resp_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;
    localparam logic [2:0] MT_WU = 3'd7;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            fcn_q, fcn_d;
    logic [2:0]      typ_q, typ_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     rd_word;
    logic            mis_d, mis_wr;
    logic [3:0]      be;
    logic            unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0]  a,
                                             input logic [2:0]  t);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            MT_B:    load_ext = {{24{b[7]}}, b};
            MT_BU:   load_ext = {24'h0, b};
            MT_H:    load_ext = {{16{h[15]}}, h};
            MT_HU:   load_ext = {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] a,
                                            input logic [2:0] t);
        case (t)
            MT_B:       store_be = 4'b0001 << a;
            MT_H:       store_be = a[1] ? 4'b1100 : 4'b0011;
            MT_W, MT_WU: store_be = 4'b1111;
            default:    store_be = 4'b0000;
        endcase
    endfunction

    // Replicate narrow store data so every enabled lane sees its bytes
    function automatic logic [31:0] store_rep(input logic [31:0] d,
                                              input logic [2:0]  t);
        case (t)
            MT_B:    store_rep = {4{d[7:0]}};
            MT_H:    store_rep = {2{d[15:0]}};
            default: store_rep = d;
        endcase
    endfunction

`ifdef SCRATCH_MEM_MISALIGN_EN
    function automatic logic misaligned(input logic [1:0] a,
                                        input logic [2:0] t);
        misaligned = ((t == MT_H || t == MT_HU) && a[0]) ||
                     ((t == MT_W || t == MT_WU) && (a != 2'b00));
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        fcn_d   = fcn_q;
        typ_d   = typ_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = req_addr[AW+1:2];
                    lane_d  = req_addr[1:0];
                    wdata_d = store_rep(req_data, req_typ);
                    fcn_d   = req_fcn;
                    typ_d   = req_typ;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load data is read on the edge entering RESP; writes only land at its end
    always_comb begin
        rd_word      = mem[idx_d];
`ifdef SCRATCH_MEM_MISALIGN_EN
        mis_d        = misaligned(lane_d, typ_d);
`else
        mis_d        = 1'b0;
`endif
        resp_valid_d = (state_d == RESP);
        resp_data_d  = '0;
        if (resp_valid_d && !fcn_d && !mis_d)
            resp_data_d = load_ext(rd_word, lane_d, typ_d);
        err_d        = resp_valid_d && mis_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            lane_q       <= '0;
            wdata_q      <= '0;
            fcn_q        <= 1'b0;
            typ_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            fcn_q        <= fcn_d;
            typ_q        <= typ_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_q        <= err_d;
        end
    end

`ifdef SCRATCH_MEM_MISALIGN_EN
    assign mis_wr = misaligned(lane_q, typ_q);
`else
    assign mis_wr = 1'b0;
`endif

    assign be = (state_q == RESP && fcn_q && !mis_wr) ?
                store_be(lane_q, typ_q) : 4'b0000;

    // Array is not reset; a reset in the RESP cycle drops the write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign resp_valid = resp_valid_q & rst;
    assign resp_data  = rst ? resp_data_q : 32'h0;
`ifdef SCRATCH_MEM_MISALIGN_EN
    assign resp_err   = err_q & rst;
`endif

endmodule
